// File: rtl/framebuffer_scanout_reader.sv
// Streams one framebuffer raster line per line_start to the laser modulator,
// prefetching pixels through a small FIFO and keeping columns mirror-aligned.
module framebuffer_scanout_reader #(
  parameter int unsigned H_PIXELS     = 640,
  parameter int unsigned V_LINES      = 480,
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  pixel_tick,
  output logic [ADDR_WIDTH-1:0] framebuffer_address,
  output logic                  framebuffer_chipselect,
  output logic                  framebuffer_clken,
  output logic                  framebuffer_write,
  output logic [DATA_WIDTH-1:0] framebuffer_writedata,
  input  logic [DATA_WIDTH-1:0] framebuffer_readdata,
  output logic [DATA_WIDTH-1:0] laser_pixel,
  output logic                  laser_pixel_valid,
  output logic                  line_active,
  output logic [9:0]            line_count,
  output logic                  underflow_flag
);
  localparam int unsigned COL_W = $clog2(H_PIXELS + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 2;
  localparam logic [COL_W-1:0]      H_COL  = COL_W'(H_PIXELS);
  localparam logic [9:0]            V_CNT  = 10'(V_LINES);
  localparam logic [OCC_W-1:0]      DEPTH  = OCC_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] H_ADDR = ADDR_WIDTH'(H_PIXELS);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]   line_base;
  logic [COL_W-1:0]        fetch_col, out_col, skip;
  logic [OCC_W-1:0]        fifo_count, inflight;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [READ_LATENCY-1:0] valid_sr;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  logic active, line_done, end_line, start_line, flush, fifo_empty;
  logic tick_ok, pop_good, discard, under_tick, rd_issue, push, pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++)
      inflight = inflight + OCC_W'(valid_sr[i]);
  end

  always_comb begin
    active     = (state == ACTIVE);
    line_done  = active && (out_col == H_COL);
    end_line   = active && (line_done || line_start);
    // frame_start rewinds to line 0 first, so a coincident line_start always starts
    start_line = line_start && (frame_start || ((line_count + 10'(end_line)) < V_CNT));
    flush      = frame_start || end_line || start_line;
    fifo_empty = (fifo_count == '0);
    tick_ok    = active && pixel_tick && !line_done;
    pop_good   = tick_ok && (skip == '0) && !fifo_empty;
    discard    = active && (skip != '0) && !fifo_empty;
    under_tick = tick_ok && !pop_good;
    rd_issue   = active && (fetch_col < H_COL) && ((fifo_count + inflight) < DEPTH);
    push       = active && valid_sr[READ_LATENCY-1];
    pop        = pop_good || discard;
    state_n    = state;
    if (start_line)
      state_n = ACTIVE;
    else if (frame_start || end_line)
      state_n = IDLE;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_ff @(posedge clk_clk) begin
    if (push && !flush)
      fifo_mem[wr_ptr] <= framebuffer_readdata;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      line_count        <= '0;
      line_base         <= '0;
      fetch_col         <= '0;
      out_col           <= '0;
      skip              <= '0;
      fifo_count        <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      valid_sr          <= '0;
      laser_pixel       <= '0;
      laser_pixel_valid <= 1'b0;
      underflow_flag    <= 1'b0;
    end else begin
      if (frame_start) begin
        line_count <= '0;
        line_base  <= '0;
      end else if (end_line) begin
        line_count <= line_count + 10'd1;
        line_base  <= line_base + H_ADDR;
      end
      // Any line boundary drops buffered and in-flight pixels of the old line
      if (flush) begin
        fetch_col         <= '0;
        out_col           <= '0;
        skip              <= '0;
        fifo_count        <= '0;
        wr_ptr            <= '0;
        rd_ptr            <= '0;
        valid_sr          <= '0;
        laser_pixel       <= '0;
        laser_pixel_valid <= 1'b0;
      end else begin
        fetch_col         <= fetch_col + COL_W'(rd_issue);
        out_col           <= out_col + COL_W'(tick_ok);
        skip              <= skip + COL_W'(under_tick) - COL_W'(discard);
        fifo_count        <= fifo_count + OCC_W'(push) - OCC_W'(pop);
        wr_ptr            <= wr_ptr + PTR_W'(push);
        rd_ptr            <= rd_ptr + PTR_W'(pop);
        valid_sr[0]       <= rd_issue;
        for (int unsigned i = 1; i < READ_LATENCY; i++)
          valid_sr[i] <= valid_sr[i-1];
        laser_pixel_valid <= tick_ok;
        if (tick_ok)
          laser_pixel <= pop_good ? fifo_mem[rd_ptr] : '0;
        else if (!active)
          laser_pixel <= '0;
      end
      if (frame_start)
        underflow_flag <= 1'b0;
      else if (under_tick && !flush)
        underflow_flag <= 1'b1;
    end
  end

  assign framebuffer_address    = line_base + ADDR_WIDTH'(fetch_col);
  assign framebuffer_chipselect = rd_issue;
  assign framebuffer_clken      = active || (inflight != '0);
  assign framebuffer_write      = 1'b0;
  assign framebuffer_writedata  = '0;
  assign line_active            = active;

endmodule

// File: tb/tb_framebuffer_scanout_reader.sv
// Scoreboard bench: expected read addresses and laser pixels are queued by the
// stimulus; a negedge monitor pops and compares as the DUT presents them.
module tb_framebuffer_scanout_reader;
  logic        clk = 1'b0;
  logic        reset_reset, frame_start, line_start, pixel_tick;
  logic [18:0] framebuffer_address;
  logic        framebuffer_chipselect, framebuffer_clken, framebuffer_write;
  logic [7:0]  framebuffer_writedata, framebuffer_readdata;
  logic [7:0]  laser_pixel;
  logic        laser_pixel_valid, line_active, underflow_flag;
  logic [9:0]  line_count;

  int checks = 0;
  int failures = 0;
  int cs_count = 0;
  int addr_q[$];
  int pix_q[$];
  logic tick_q = 1'b0;

  always #5 clk = ~clk;

  framebuffer_scanout_reader #(
    .H_PIXELS(8), .V_LINES(4), .ADDR_WIDTH(19), .DATA_WIDTH(8),
    .READ_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .frame_start(frame_start), .line_start(line_start), .pixel_tick(pixel_tick),
    .framebuffer_address(framebuffer_address),
    .framebuffer_chipselect(framebuffer_chipselect),
    .framebuffer_clken(framebuffer_clken),
    .framebuffer_write(framebuffer_write),
    .framebuffer_writedata(framebuffer_writedata),
    .framebuffer_readdata(framebuffer_readdata),
    .laser_pixel(laser_pixel), .laser_pixel_valid(laser_pixel_valid),
    .line_active(line_active), .line_count(line_count),
    .underflow_flag(underflow_flag)
  );

  // Memory preloaded with data = address[7:0], one-cycle read latency
  always @(posedge clk) begin
    if (framebuffer_chipselect) framebuffer_readdata <= framebuffer_address[7:0];
    tick_q <= pixel_tick;
  end

  always @(negedge clk) begin
    int exp;
    if (framebuffer_chipselect) begin
      cs_count++;
      checks++;
      if (addr_q.size() == 0) begin
        failures++;
        $display("FAIL read_addr: unexpected read at address %0d", framebuffer_address);
      end else begin
        exp = addr_q.pop_front();
        if (int'(framebuffer_address) != exp) begin
          failures++;
          $display("FAIL read_addr: actual=%0d expected=%0d", framebuffer_address, exp);
        end
      end
    end
    if (laser_pixel_valid) begin
      checks++;
      if (pix_q.size() == 0) begin
        failures++;
        $display("FAIL laser_pixel: unexpected pixel %0d", laser_pixel);
      end else begin
        exp = pix_q.pop_front();
        if (int'(laser_pixel) != exp) begin
          failures++;
          $display("FAIL laser_pixel: actual=%0d expected=%0d", laser_pixel, exp);
        end
      end
      checks++;
      if (!tick_q) begin
        failures++;
        $display("FAIL pixel_latency: valid=1 without tick on previous edge, tick_q=%0d expected=1", tick_q);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reads(input int first, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(first + i);
  endtask

  task automatic expect_pixels(input int first, input int n);
    for (int i = 0; i < n; i++) pix_q.push_back(first + i);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_tick = 1'b1;
      step();
      pixel_tick = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  initial begin
    reset_reset = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pixel_tick  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_start = 1'($urandom_range(0, 1));
      line_start  = 1'($urandom_range(0, 1));
      pixel_tick  = 1'($urandom_range(0, 1));
      step();
    end
    frame_start = 1'b0;
    line_start  = 1'b0;
    pixel_tick  = 1'b0;
    check("rst_laser_pixel", int'(laser_pixel), 0);
    check("rst_valid", int'(laser_pixel_valid), 0);
    check("rst_line_active", int'(line_active), 0);
    check("rst_line_count", int'(line_count), 0);
    check("rst_underflow", int'(underflow_flag), 0);
    check("rst_address", int'(framebuffer_address), 0);
    check("rst_clken", int'(framebuffer_clken), 0);
    check("rst_write", int'(framebuffer_write) + int'(framebuffer_writedata), 0);
    reset_reset = 1'b0;
    step();

    // Line 0: prefetch fills exactly four slots before any tick
    expect_reads(0, 8);
    expect_pixels(0, 8);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pulse_line();
    check("l0_active", int'(line_active), 1);
    repeat (10) step();
    check("l0_prefetch_reads", cs_count, 4);
    ticks(8);
    check("l0_line_active", int'(line_active), 0);
    check("l0_line_count", int'(line_count), 1);
    check("l0_underflow", int'(underflow_flag), 0);
    check("l0_idle_pixel", int'(laser_pixel), 0);

    // Line 1
    expect_reads(8, 8);
    expect_pixels(8, 8);
    pulse_line();
    repeat (10) step();
    ticks(8);
    check("l1_line_count", int'(line_count), 2);
    check("l1_underflow", int'(underflow_flag), 0);

    // Line 2: tick right after line_start underflows; 16 is discarded to stay aligned
    expect_reads(16, 8);
    pix_q.push_back(0);
    expect_pixels(17, 7);
    pulse_line();
    ticks(8);
    check("l2_underflow", int'(underflow_flag), 1);
    check("l2_line_count", int'(line_count), 3);
    check("l2_line_active", int'(line_active), 0);

    // Line 3 aborted after three pixels; vertical blanking follows
    expect_reads(24, 7);
    expect_pixels(24, 3);
    pulse_line();
    repeat (10) step();
    ticks(3);
    pulse_line();
    step();
    check("abort_line_count", int'(line_count), 4);
    check("abort_line_active", int'(line_active), 0);
    check("abort_next_address", int'(framebuffer_address), 32);
    check("abort_laser_pixel", int'(laser_pixel), 0);
    check("abort_clken", int'(framebuffer_clken), 0);

    pulse_line();
    repeat (5) step();
    check("blank_line_active", int'(line_active), 0);
    check("blank_line_count", int'(line_count), 4);
    check("blank_laser_pixel", int'(laser_pixel), 0);

    // Coincident frame_start + line_start restarts line 0
    expect_reads(0, 8);
    expect_pixels(0, 8);
    frame_start = 1'b1;
    line_start  = 1'b1;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    check("restart_underflow_cleared", int'(underflow_flag), 0);
    check("restart_line_active", int'(line_active), 1);
    check("restart_line_count", int'(line_count), 0);
    repeat (10) step();
    ticks(8);
    check("restart_line_count_end", int'(line_count), 1);
    check("restart_underflow_end", int'(underflow_flag), 0);

    repeat (5) step();
    check("reads_outstanding", addr_q.size(), 0);
    check("pixels_outstanding", pix_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/framebuffer_scanout_reader.md
Name: framebuffer_scanout_reader

Overview:
- Read-side counterpart of the video-in framebuffer writer: scans the 8-bit frame buffer line by line and streams pixels to the laser modulator.
- Each mirror-facet `line_start` pulse begins one raster line. Pixels are prefetched through the framebuffer slave port into a small FIFO.
- One pixel is presented per `pixel_tick` strobe.
- Sits between the on-chip framebuffer (the port the video-in path writes) and the laser driver / polygon mirror control.

Parameters:
- H_PIXELS, 640, pixels per line.
- V_LINES, 480, lines per frame.
- ADDR_WIDTH, 19, framebuffer address width.
- DATA_WIDTH, 8, pixel width.
- READ_LATENCY, 1, cycles from chipselect to valid readdata (1 or 2).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >= READ_LATENCY+2).

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: return to line 0.
- line_start  in  1  one-cycle pulse: begin next raster line.
- pixel_tick  in  1  one-cycle strobe, already in clk_clk domain: laser consumes one pixel.
- framebuffer_address  out  ADDR_WIDTH  read address.
- framebuffer_chipselect  out  1  read request, one cycle per word.
- framebuffer_clken  out  1  memory clock enable.
- framebuffer_write  out  1  tied 0.
- framebuffer_writedata  out  DATA_WIDTH  tied 0.
- framebuffer_readdata  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after chipselect.
- laser_pixel  out  DATA_WIDTH  current pixel intensity.
- laser_pixel_valid  out  1  one-cycle pulse with each tick-driven update.
- line_active  out  1  high while a line is being output.
- line_count  out  10  index of the next line to be started.
- underflow_flag  out  1  sticky: a tick found no pixel available.

Behaviour:
- Reset: all outputs 0; FIFO, in-flight count, skip count and counters cleared; state IDLE.
- States:
  - IDLE: on `line_start` with line_count < V_LINES, go to ACTIVE.
  - ACTIVE: when out_col reaches H_PIXELS, go to IDLE and increment line_count.
  - `line_start` while line_count >= V_LINES is ignored (vertical blanking): no reads, outputs stay 0.
- Addressing:
  - Address = line_base + fetch_col.
  - line_base is accumulated by adding H_PIXELS per completed line and reset to 0 by `frame_start`. No multiplier.
- Fetch:
  - In ACTIVE, issue a read (chipselect=1 for one cycle) when fetch_col < H_PIXELS and fifo_count + inflight < FIFO_DEPTH.
  - fetch_col increments per issued read.
  - readdata is pushed READ_LATENCY cycles later via a valid shift register.
  - clken=1 whenever ACTIVE or inflight > 0.
- Output:
  - `pixel_tick` in ACTIVE with skip=0 and FIFO non-empty: pop; laser_pixel <= data next cycle; laser_pixel_valid=1 for that cycle; out_col+1.
  - Latency tick -> laser_pixel is 1 cycle.
  - laser_pixel holds between ticks; it is 0 whenever not ACTIVE.
- Underflow:
  - `pixel_tick` in ACTIVE with FIFO empty or skip>0: laser_pixel <= 0, valid pulses, out_col+1, underflow_flag <= 1, skip+1.
  - While skip>0 and FIFO non-empty (no tick), pop and discard, skip-1. This keeps columns aligned to mirror position.
  - Simultaneous tick and discard opportunity: the tick is treated as underflow, and one entry is discarded that cycle.
- Line abort: `line_start` in ACTIVE ends the current line (line_count+1, line_base += H_PIXELS) and then starts the next line if still < V_LINES.
  - FIFO, skip and columns flush.
  - In-flight returns are dropped: the valid pipeline is cleared.
- `frame_start`:
  - line_count=0, line_base=0, state IDLE, FIFO flushed, underflow_flag cleared.
  - If coincident with `line_start`, frame_start applies first and line 0 starts that cycle.
- `line_count` is 10 bits: V_LINES <= 1023.
- Reset mid-line: reset takes effect on the next edge and overrides every other input.

Test Plan (H_PIXELS=8, V_LINES=4, READ_LATENCY=1, memory preloaded data=address[7:0]):
- Reset asserted with all inputs toggling -> all outputs 0, no chipselect.
- frame_start, line_start, wait 10 cycles, 8 ticks every 4 cycles -> reads at addresses 0..7 (at most 4 outstanding/buffered), laser_pixel 0,1..7 each 1 cycle after its tick, line_active falls after the 8th tick, line_count=1, underflow_flag=0.
- Second line_start, same ticks -> addresses 8..15, laser_pixel 8..15.
- line_start followed by a tick on the very next cycle, then ticks every 4 cycles -> first laser_pixel 0, underflow_flag=1, later ticks show 17..23 (column-aligned, value 16 discarded).
- Abort: line_start, 3 ticks (24,25,26), line_start -> FIFO flushed, new reads start at address 32, line_count=4 after line 4 ends.
- Blanking: line_start with line_count=4 -> no chipselect, line_active=0. frame_start+line_start same cycle -> reads restart at address 0, underflow_flag cleared.
